// File: rtl/sdram_pkg.sv
// Shared widths, tester state encoding and LFSR constants for the SDRAM pattern tester.
package sdram_pkg;
  localparam int SD_ADDR_WIDTH = 25;
  localparam int SD_DATA_WIDTH = 8;
  // x^8+x^6+x^5+x^4+1 in left-shifting Galois form (feedback into bits 6,5,4,0)
  localparam logic [7:0] LFSR_TAPS = 8'h71;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_REQ, ST_RD_REQ, ST_RD_WAIT, ST_DONE
  } tester_state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], 1'b0} ^ (q[7] ? LFSR_TAPS : 8'h00);
  endfunction
endpackage

// File: rtl/sdram_pattern_gen.sv
// Byte pattern source for the tester: address XOR seed, or an 8-bit Galois LFSR
// when SDRAM_TESTER_LFSR_EN is defined (reloaded at the start of each phase).
module sdram_pattern_gen
  import sdram_pkg::*;
(
`ifdef SDRAM_TESTER_LFSR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
`else
  input  logic [7:0] addr_i,
`endif
  input  logic [7:0] seed_i,
  output logic [7:0] pattern_o
);
`ifdef SDRAM_TESTER_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    // an all-zero state would never leave zero
    if (load_i)      lfsr_d = (seed_i == 8'h00) ? 8'h01 : seed_i;
    else if (step_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

  assign pattern_o = lfsr_q;
`else
  assign pattern_o = addr_i ^ seed_i;
`endif
endmodule

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test client: writes a seeded byte pattern over an address window, reads it back
// and reports mismatches/timeouts. Define SDRAM_TESTER_LFSR_EN for an LFSR pattern instead.
module sdram_pattern_tester
  import sdram_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = SD_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = SD_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    WORD_COUNT     = 1024,
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [15:0]           error_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_enable,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready,
  input  logic                  ack
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'(WORD_COUNT - 1);

  tester_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, first_q, first_d;
  logic [7:0]            seed_q, seed_d, pattern;
  logic [15:0]           err_q, err_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  gap_q, gap_d, busy_q, busy_d, done_q, done_d, tmo_q, tmo_d;
  logic                  wr_acc, rd_acc, cmp_now, tmo_hit, rd_fin, rec_err, is_last;

  // gap_q blanks the request for the cycle after an ack so requests are never back-to-back
  assign wr_enable = (state_q == ST_WR_REQ) && !gap_q;
  assign rd_enable = (state_q == ST_RD_REQ) && !gap_q;
  assign wr_acc    = wr_enable && ack;
  assign rd_acc    = rd_enable && ack;
  assign cmp_now   = (rd_acc || state_q == ST_RD_WAIT) && rd_ready;
  assign tmo_hit   = (state_q == ST_RD_WAIT) && !rd_ready && (timer_q == TW'(TIMEOUT_CYCLES));
  assign rd_fin    = cmp_now || tmo_hit;
  assign rec_err   = tmo_hit || (cmp_now && (rd_data != DATA_WIDTH'(pattern)));
  assign is_last   = (addr_q == LAST_ADDR);

  assign wr_addr        = addr_q;
  assign rd_addr        = addr_q;
  assign wr_data        = DATA_WIDTH'(pattern);
  assign busy           = busy_q;
  assign done           = done_q;
  assign timeout        = tmo_q;
  assign error_count    = err_q;
  assign first_err_addr = first_q;
  assign pass           = done_q && (err_q == 16'h0000) && !tmo_q;

`ifdef SDRAM_TESTER_LFSR_EN
  logic pat_load, pat_step;
  assign pat_load = ((state_q == ST_IDLE) && start) || (wr_acc && is_last);
  assign pat_step = (wr_acc && !is_last) || rd_fin;
  sdram_pattern_gen u_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pat_load),
    .step_i    (pat_step),
    .seed_i    ((state_q == ST_IDLE) ? seed[7:0] : seed_q),
    .pattern_o (pattern)
  );
`else
  sdram_pattern_gen u_gen (
    .addr_i    (addr_q[7:0]),
    .seed_i    (seed_q),
    .pattern_o (pattern)
  );
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    gap_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    first_d = first_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_WR_REQ;
        addr_d  = BASE_ADDR;
        seed_d  = seed[7:0];
        busy_d  = 1'b1;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        err_d   = '0;
        first_d = '0;
      end
      ST_WR_REQ: if (wr_acc) begin
        gap_d = 1'b1;
        if (is_last) begin
          addr_d  = BASE_ADDR;
          state_d = ST_RD_REQ;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      ST_RD_REQ: if (rd_acc) begin
        gap_d   = 1'b1;
        timer_d = '0;
        if (!rd_ready) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: if (!rd_ready) timer_d = timer_q + TW'(1);
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    if (rd_fin) begin
      if (rec_err) begin
        if (err_q == 16'h0000) first_d = addr_q;
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      end
      if (tmo_hit) tmo_d = 1'b1;
      if (is_last) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        state_d = ST_RD_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      gap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      first_q <= first_d;
      timer_q <= timer_d;
    end
  end
endmodule
